// File: rtl/issue_scheduler_pkg.sv
// issue_scheduler_pkg: shared widths and reservation-station entry layout
package issue_scheduler_pkg;

    localparam int TAG_W     = 6;
    localparam int ROB_W     = 6;
    localparam int DATA_W    = 32;
    localparam int ALUCTRL_W = 4;

    typedef struct packed {
        logic                 valid;
        logic [ALUCTRL_W-1:0] alu_control;
        logic                 alu_src;
        logic                 is_for_lsq;
        logic [DATA_W-1:0]    imm;
        logic                 rs1_ready;
        logic [TAG_W-1:0]     rs1_tag;
        logic [DATA_W-1:0]    rs1_value;
        logic                 rs2_ready;
        logic [TAG_W-1:0]     rs2_tag;
        logic [DATA_W-1:0]    rs2_value;
        logic [TAG_W-1:0]     dest_tag;
        logic [ROB_W-1:0]     rob_index;
    } rs_entry_t;

endpackage

// File: rtl/issue_scheduler_picker.sv
// priority_picker: lowest-index one-hot grant plus any-request flag
module priority_picker #(
    parameter int N = 8
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] grant,
    output logic         any
);

    // two's complement isolates the lowest set bit
    assign grant = req & (-req);
    assign any   = |req;

endmodule

// File: rtl/issue_scheduler.sv
// issue_scheduler: reservation station with operand wakeup and single-issue select
module issue_scheduler
    import issue_scheduler_pkg::*;
#(
    parameter int NUM_ENTRIES = 8,
    parameter int NUM_FU      = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        dispatch_valid,
    output logic                        dispatch_ready,
    input  logic [ALUCTRL_W-1:0]        dispatch_ALUControl,
    input  logic                        dispatch_ALUSrc,
    input  logic                        dispatch_is_for_lsq,
    input  logic [DATA_W-1:0]           dispatch_imm,
    input  logic [TAG_W-1:0]            dispatch_rs1_tag,
    input  logic [TAG_W-1:0]            dispatch_rs2_tag,
    input  logic                        dispatch_rs1_ready,
    input  logic                        dispatch_rs2_ready,
    input  logic [DATA_W-1:0]           dispatch_rs1_value,
    input  logic [DATA_W-1:0]           dispatch_rs2_value,
    input  logic [TAG_W-1:0]            dispatch_tag_to_output,
    input  logic [ROB_W-1:0]            dispatch_rob_index,
    input  logic [NUM_FU-1:0]           fu_available,
    input  logic [NUM_FU-1:0]           wakeup_active,
    input  logic [TAG_W*NUM_FU-1:0]     wakeup_tag,
    input  logic [DATA_W*NUM_FU-1:0]    wakeup_value,
    output logic [NUM_FU-1:0]           issue_write_enable,
    output logic [ALUCTRL_W-1:0]        issue_ALUControl,
    output logic                        issue_ALUSrc,
    output logic                        issue_is_for_lsq,
    output logic [DATA_W-1:0]           issue_imm,
    output logic [DATA_W-1:0]           issue_rs1_value,
    output logic [DATA_W-1:0]           issue_rs2_value,
    output logic [TAG_W-1:0]            issue_tag_to_output,
    output logic [ROB_W-1:0]            issue_rob_index,
    output logic [$clog2(NUM_ENTRIES):0] occupancy
);

    localparam int OCC_W = $clog2(NUM_ENTRIES) + 1;

    rs_entry_t entries     [NUM_ENTRIES];
    rs_entry_t entries_nxt [NUM_ENTRIES];
    rs_entry_t new_entry;
    rs_entry_t picked;

    logic [NUM_ENTRIES-1:0] valid_vec;
    logic [NUM_ENTRIES-1:0] elig_vec;
    logic [NUM_ENTRIES-1:0] alloc_grant;
    logic [NUM_ENTRIES-1:0] sel_grant;
    logic [NUM_FU-1:0]      fu_grant;
    logic                   alloc_any;
    logic                   elig_any;
    logic                   fu_any;
    logic                   do_issue;
    logic                   do_dispatch;
    logic [DATA_W:0]        wk1;
    logic [DATA_W:0]        wk2;
    logic [DATA_W:0]        ew1;
    logic [DATA_W:0]        ew2;

    // {hit, value}; descending scan lets the lowest FU index win
    function automatic logic [DATA_W:0] wake_lookup(
        input logic [TAG_W-1:0]        tag,
        input logic [NUM_FU-1:0]       act,
        input logic [TAG_W*NUM_FU-1:0] tags,
        input logic [DATA_W*NUM_FU-1:0] vals
    );
        logic [DATA_W:0] r;
        r = '0;
        for (int f = NUM_FU - 1; f >= 0; f--)
            if (act[f] && tags[TAG_W*f +: TAG_W] == tag)
                r = {1'b1, vals[DATA_W*f +: DATA_W]};
        return r;
    endfunction

    always_comb begin
        valid_vec = '0;
        elig_vec  = '0;
        occupancy = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            valid_vec[i] = entries[i].valid;
            elig_vec[i]  = entries[i].valid && entries[i].rs1_ready && entries[i].rs2_ready;
            occupancy    = occupancy + OCC_W'(entries[i].valid);
        end
    end

    priority_picker #(.N(NUM_ENTRIES)) u_alloc (.req(~valid_vec), .grant(alloc_grant), .any(alloc_any));
    priority_picker #(.N(NUM_ENTRIES)) u_select (.req(elig_vec), .grant(sel_grant), .any(elig_any));
    priority_picker #(.N(NUM_FU)) u_fu (.req(fu_available), .grant(fu_grant), .any(fu_any));

    assign dispatch_ready = !reset && alloc_any;
    assign do_dispatch    = dispatch_valid && dispatch_ready;
    assign do_issue       = !reset && elig_any && fu_any;

    always_comb begin
        wk1 = wake_lookup(dispatch_rs1_tag, wakeup_active, wakeup_tag, wakeup_value);
        wk2 = wake_lookup(dispatch_rs2_tag, wakeup_active, wakeup_tag, wakeup_value);
        new_entry             = '0;
        new_entry.valid       = 1'b1;
        new_entry.alu_control = dispatch_ALUControl;
        new_entry.alu_src     = dispatch_ALUSrc;
        new_entry.is_for_lsq  = dispatch_is_for_lsq;
        new_entry.imm         = dispatch_imm;
        new_entry.rs1_tag     = dispatch_rs1_tag;
        new_entry.rs2_tag     = dispatch_rs2_tag;
        new_entry.dest_tag    = dispatch_tag_to_output;
        new_entry.rob_index   = dispatch_rob_index;
        new_entry.rs1_ready   = dispatch_rs1_tag == '0 || dispatch_rs1_ready || wk1[DATA_W];
        new_entry.rs2_ready   = dispatch_rs2_tag == '0 || dispatch_rs2_ready || wk2[DATA_W] || dispatch_ALUSrc;
        new_entry.rs1_value   = dispatch_rs1_tag == '0 ? '0 : dispatch_rs1_ready ? dispatch_rs1_value : wk1[DATA_W-1:0];
        new_entry.rs2_value   = dispatch_rs2_tag == '0 ? '0 : dispatch_rs2_ready ? dispatch_rs2_value : wk2[DATA_W-1:0];
    end

    always_comb begin
        entries_nxt = entries;
        ew1 = '0;
        ew2 = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            ew1 = wake_lookup(entries[i].rs1_tag, wakeup_active, wakeup_tag, wakeup_value);
            ew2 = wake_lookup(entries[i].rs2_tag, wakeup_active, wakeup_tag, wakeup_value);
            if (entries[i].valid && !entries[i].rs1_ready && ew1[DATA_W]) begin
                entries_nxt[i].rs1_ready = 1'b1;
                entries_nxt[i].rs1_value = ew1[DATA_W-1:0];
            end
            if (entries[i].valid && !entries[i].rs2_ready && ew2[DATA_W]) begin
                entries_nxt[i].rs2_ready = 1'b1;
                entries_nxt[i].rs2_value = ew2[DATA_W-1:0];
            end
            if (do_issue && sel_grant[i])
                entries_nxt[i].valid = 1'b0;
            if (do_dispatch && alloc_grant[i])
                entries_nxt[i] = new_entry;
        end
    end

    always_ff @(posedge clk)
        if (reset)
            entries <= '{default: '0};
        else
            entries <= entries_nxt;

    // sel_grant is one-hot, so at most one entry drives the bus
    always_comb begin
        picked = '0;
        for (int i = 0; i < NUM_ENTRIES; i++)
            if (sel_grant[i])
                picked = entries[i];
        issue_write_enable  = do_issue ? fu_grant : '0;
        issue_ALUControl    = do_issue ? picked.alu_control : '0;
        issue_ALUSrc        = do_issue ? picked.alu_src : 1'b0;
        issue_is_for_lsq    = do_issue ? picked.is_for_lsq : 1'b0;
        issue_imm           = do_issue ? picked.imm : '0;
        issue_rs1_value     = do_issue ? picked.rs1_value : '0;
        issue_rs2_value     = do_issue ? picked.rs2_value : '0;
        issue_tag_to_output = do_issue ? picked.dest_tag : '0;
        issue_rob_index     = do_issue ? picked.rob_index : '0;
    end

endmodule

// File: tb/tb_issue_scheduler.sv
// tb_issue_scheduler: directed checks of dispatch, wakeup, select and reset
module tb_issue_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        dispatch_valid;
    logic        dispatch_ready;
    logic [3:0]  dispatch_ALUControl;
    logic        dispatch_ALUSrc;
    logic        dispatch_is_for_lsq;
    logic [31:0] dispatch_imm;
    logic [5:0]  dispatch_rs1_tag;
    logic [5:0]  dispatch_rs2_tag;
    logic        dispatch_rs1_ready;
    logic        dispatch_rs2_ready;
    logic [31:0] dispatch_rs1_value;
    logic [31:0] dispatch_rs2_value;
    logic [5:0]  dispatch_tag_to_output;
    logic [5:0]  dispatch_rob_index;
    logic [2:0]  fu_available;
    logic [2:0]  wakeup_active;
    logic [17:0] wakeup_tag;
    logic [95:0] wakeup_value;
    logic [2:0]  issue_write_enable;
    logic [3:0]  issue_ALUControl;
    logic        issue_ALUSrc;
    logic        issue_is_for_lsq;
    logic [31:0] issue_imm;
    logic [31:0] issue_rs1_value;
    logic [31:0] issue_rs2_value;
    logic [5:0]  issue_tag_to_output;
    logic [5:0]  issue_rob_index;
    logic [3:0]  occupancy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    issue_scheduler #(.NUM_ENTRIES(8), .NUM_FU(3)) dut (
        .clk(clk), .reset(reset),
        .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
        .dispatch_ALUControl(dispatch_ALUControl), .dispatch_ALUSrc(dispatch_ALUSrc),
        .dispatch_is_for_lsq(dispatch_is_for_lsq), .dispatch_imm(dispatch_imm),
        .dispatch_rs1_tag(dispatch_rs1_tag), .dispatch_rs2_tag(dispatch_rs2_tag),
        .dispatch_rs1_ready(dispatch_rs1_ready), .dispatch_rs2_ready(dispatch_rs2_ready),
        .dispatch_rs1_value(dispatch_rs1_value), .dispatch_rs2_value(dispatch_rs2_value),
        .dispatch_tag_to_output(dispatch_tag_to_output), .dispatch_rob_index(dispatch_rob_index),
        .fu_available(fu_available), .wakeup_active(wakeup_active),
        .wakeup_tag(wakeup_tag), .wakeup_value(wakeup_value),
        .issue_write_enable(issue_write_enable), .issue_ALUControl(issue_ALUControl),
        .issue_ALUSrc(issue_ALUSrc), .issue_is_for_lsq(issue_is_for_lsq),
        .issue_imm(issue_imm), .issue_rs1_value(issue_rs1_value),
        .issue_rs2_value(issue_rs2_value), .issue_tag_to_output(issue_tag_to_output),
        .issue_rob_index(issue_rob_index), .occupancy(occupancy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [3:0] op, input logic src, input logic [5:0] t1, input logic r1,
                        input logic [31:0] v1, input logic [5:0] t2, input logic r2,
                        input logic [31:0] imm, input logic [5:0] dest, input logic [5:0] rob);
        dispatch_valid         = 1'b1;
        dispatch_ALUControl    = op;
        dispatch_ALUSrc        = src;
        dispatch_imm           = imm;
        dispatch_rs1_tag       = t1;
        dispatch_rs1_ready     = r1;
        dispatch_rs1_value     = v1;
        dispatch_rs2_tag       = t2;
        dispatch_rs2_ready     = r2;
        dispatch_rs2_value     = 32'h0;
        dispatch_tag_to_output = dest;
        dispatch_rob_index     = rob;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        dispatch_valid = 1'b0;
        dispatch_is_for_lsq = 1'b0;
        send(4'h0, 1'b0, 6'd0, 1'b0, 32'h0, 6'd0, 1'b0, 32'h0, 6'd0, 6'd0);
        dispatch_valid = 1'b0;
        fu_available = 3'b000;
        wakeup_active = 3'b000;
        wakeup_tag = '0;
        wakeup_value = '0;
        tick();
        tick();
        check("rst_occ", 32'(occupancy), 32'd0);
        check("rst_rdy", 32'(dispatch_ready), 32'd0);
        check("rst_we", 32'(issue_write_enable), 32'd0);
        reset = 1'b0;
        #1 check("rdy_after_rst", 32'(dispatch_ready), 32'd1);

        // basic dispatch then issue
        fu_available = 3'b111;
        send(4'h2, 1'b0, 6'd0, 1'b0, 32'h0, 6'd0, 1'b0, 32'h0, 6'd4, 6'd3);
        #1 check("t1_pre_we", 32'(issue_write_enable), 32'd0);
        tick();
        dispatch_valid = 1'b0;
        check("t1_we", 32'(issue_write_enable), 32'b001);
        check("t1_dest", 32'(issue_tag_to_output), 32'd4);
        check("t1_rob", 32'(issue_rob_index), 32'd3);
        check("t1_op", 32'(issue_ALUControl), 32'd2);
        check("t1_occ", 32'(occupancy), 32'd1);
        tick();
        check("t1_occ_after", 32'(occupancy), 32'd0);
        check("t1_we_after", 32'(issue_write_enable), 32'd0);

        // wakeup capture, lowest FU wins, no same-cycle bypass
        send(4'h1, 1'b0, 6'd9, 1'b0, 32'h0, 6'd0, 1'b0, 32'h0, 6'd5, 6'd7);
        tick();
        dispatch_valid = 1'b0;
        check("t2_wait_we", 32'(issue_write_enable), 32'd0);
        check("t2_wait_occ", 32'(occupancy), 32'd1);
        tick();
        check("t2_wait2_we", 32'(issue_write_enable), 32'd0);
        wakeup_active = 3'b110;
        wakeup_tag    = {6'd9, 6'd9, 6'd0};
        wakeup_value  = {32'hAA, 32'h55, 32'h0};
        #1 check("t2_nobypass", 32'(issue_write_enable), 32'd0);
        tick();
        wakeup_active = 3'b000;
        check("t2_we", 32'(issue_write_enable), 32'b001);
        check("t2_v1", issue_rs1_value, 32'h55);
        check("t2_dest", 32'(issue_tag_to_output), 32'd5);
        tick();
        check("t2_occ", 32'(occupancy), 32'd0);

        // fill to capacity, drop a ninth, free via issue
        for (int i = 0; i < 8; i++) begin
            send(4'h0, 1'b0, 6'(20 + i), 1'b0, 32'h0, 6'd0, 1'b0, 32'h0, 6'(i), 6'(i));
            tick();
        end
        send(4'h0, 1'b0, 6'd40, 1'b0, 32'h0, 6'd0, 1'b0, 32'h0, 6'd63, 6'd63);
        check("full_occ", 32'(occupancy), 32'd8);
        check("full_rdy", 32'(dispatch_ready), 32'd0);
        check("full_we", 32'(issue_write_enable), 32'd0);
        tick();
        dispatch_valid = 1'b0;
        check("drop_occ", 32'(occupancy), 32'd8);
        wakeup_active = 3'b001;
        wakeup_tag    = {12'd0, 6'd23};
        wakeup_value  = {64'h0, 32'h123};
        tick();
        wakeup_active = 3'b000;
        check("t3_we", 32'(issue_write_enable), 32'b001);
        check("t3_dest", 32'(issue_tag_to_output), 32'd3);
        check("t3_v1", issue_rs1_value, 32'h123);
        check("t3_rdy_still_full", 32'(dispatch_ready), 32'd0);
        tick();
        check("t3_occ", 32'(occupancy), 32'd7);
        check("t3_rdy", 32'(dispatch_ready), 32'd1);
        wakeup_active = 3'b001;
        wakeup_tag    = {12'd0, 6'd24};
        tick();
        wakeup_active = 3'b000;
        check("same_edge_we", 32'(issue_write_enable), 32'b001);
        check("same_edge_dest", 32'(issue_tag_to_output), 32'd4);
        send(4'h0, 1'b0, 6'd50, 1'b0, 32'h0, 6'd0, 1'b0, 32'h0, 6'd50, 6'd50);
        tick();
        dispatch_valid = 1'b0;
        check("same_edge_occ", 32'(occupancy), 32'd7);
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // two eligible entries, restricted FU availability
        fu_available = 3'b000;
        send(4'h0, 1'b0, 6'd0, 1'b0, 32'h0, 6'd0, 1'b0, 32'h0, 6'd10, 6'd10);
        tick();
        send(4'h0, 1'b0, 6'd0, 1'b0, 32'h0, 6'd0, 1'b0, 32'h0, 6'd11, 6'd11);
        tick();
        dispatch_valid = 1'b0;
        check("t4_occ", 32'(occupancy), 32'd2);
        check("t4_no_fu_we", 32'(issue_write_enable), 32'd0);
        fu_available = 3'b100;
        #1 check("t4_we_fu2", 32'(issue_write_enable), 32'b100);
        check("t4_dest0", 32'(issue_tag_to_output), 32'd10);
        tick();
        fu_available = 3'b000;
        #1 check("t4_wait_we", 32'(issue_write_enable), 32'd0);
        check("t4_wait_occ", 32'(occupancy), 32'd1);
        fu_available = 3'b010;
        #1 check("t4_we_fu1", 32'(issue_write_enable), 32'b010);
        check("t4_dest1", 32'(issue_tag_to_output), 32'd11);
        tick();
        check("t4_occ_end", 32'(occupancy), 32'd0);

        // immediate form ignores an un-woken rs2
        fu_available = 3'b111;
        send(4'h3, 1'b1, 6'd7, 1'b1, 32'hDEAD, 6'd12, 1'b0, 32'h1234, 6'd13, 6'd13);
        tick();
        dispatch_valid = 1'b0;
        check("t5_we", 32'(issue_write_enable), 32'b001);
        check("t5_alusrc", 32'(issue_ALUSrc), 32'd1);
        check("t5_imm", issue_imm, 32'h1234);
        check("t5_v1", issue_rs1_value, 32'hDEAD);
        tick();

        // wakeup arriving in the dispatch cycle
        send(4'h0, 1'b0, 6'd33, 1'b0, 32'h0, 6'd0, 1'b0, 32'h0, 6'd14, 6'd14);
        wakeup_active = 3'b001;
        wakeup_tag    = {12'd0, 6'd33};
        wakeup_value  = {64'h0, 32'h77};
        tick();
        dispatch_valid = 1'b0;
        wakeup_active  = 3'b000;
        check("disp_wake_we", 32'(issue_write_enable), 32'b001);
        check("disp_wake_v1", issue_rs1_value, 32'h77);
        tick();

        // reset with valid entries pending
        fu_available = 3'b000;
        for (int i = 0; i < 5; i++) begin
            send(4'h0, 1'b0, 6'd0, 1'b0, 32'h0, 6'd0, 1'b0, 32'h0, 6'(20 + i), 6'(i));
            tick();
        end
        dispatch_valid = 1'b0;
        check("t6_occ", 32'(occupancy), 32'd5);
        fu_available = 3'b111;
        reset = 1'b1;
        #1 check("t6_rst_we", 32'(issue_write_enable), 32'd0);
        check("t6_rst_rdy", 32'(dispatch_ready), 32'd0);
        tick();
        check("t6_occ_rst", 32'(occupancy), 32'd0);
        reset = 1'b0;
        #1 check("t6_no_stale", 32'(issue_write_enable), 32'd0);
        tick();
        check("t6_no_stale2", 32'(issue_write_enable), 32'd0);
        check("t6_occ_end", 32'(occupancy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
